// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker
//   Keeps the DEC, EX and MEM pipeline latch words for one core. It exposes
//   their register fields to the hazard unit with zero latency. It then applies
//   the hazard unit's freeze_fd / freeze_dex / flush requests, and the dcache
//   wait, to those latches.
//
// Ports
//   CLK, RST        core clock; synchronous active-high reset
//   instr_fetch     word arriving from fetch
//   freeze_fd       hold DEC, bubble into EX
//   freeze_dex      hold DEC+EX, bubble into MEM
//   flush           kill DEC+EX (taken branch/jump); beats both freezes
//   dhit            dcache hit for the MEM-stage access
//   instr_dec/ex/mem  latch contents
//   rs_dec, rt_dec, rt_ex, rd_ex, rt_mem, rd_mem  register field slices
//   rw_memory       destination register of instr_mem (0 = none)
//   mem_regwrite    instr_mem writes a nonzero register
//   pc_en           fetch may advance this cycle
//   stall_cycles    saturating count of edges seen with pc_en low
module hazard_pipe_tracker #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      instr_fetch,
  input  logic             freeze_fd,
  input  logic             freeze_dex,
  input  logic             flush,
  input  logic             dhit,
  output logic [31:0]      instr_dec,
  output logic [31:0]      instr_ex,
  output logic [31:0]      instr_mem,
  output logic [4:0]       rs_dec,
  output logic [4:0]       rt_dec,
  output logic [4:0]       rt_ex,
  output logic [4:0]       rd_ex,
  output logic [4:0]       rt_mem,
  output logic [4:0]       rd_mem,
  output logic [4:0]       rw_memory,
  output logic             mem_regwrite,
  output logic             pc_en,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_LL      = 6'h30;
  localparam logic [5:0] OP_SC      = 6'h38;
  localparam logic [5:0] FN_JR      = 6'h08;

  logic [31:0]      dec_q, dec_d;
  logic [31:0]      ex_q, ex_d;
  logic [31:0]      mem_q, mem_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [5:0] mem_op;
  logic [5:0] mem_funct;
  logic       mem_is_access;
  logic       mem_hold;

  assign mem_op    = mem_q[31:26];
  assign mem_funct = mem_q[5:0];

  // Any data-memory access in MEM waits for the dcache; the whole pipe freezes.
  always_comb begin
    mem_is_access = 1'b0;
    case (mem_op)
      OP_LW, OP_SW, OP_LL, OP_SC: mem_is_access = 1'b1;
      default:                    mem_is_access = 1'b0;
    endcase
  end

  assign mem_hold = mem_is_access & ~dhit;

  // A flush redirects fetch, so the PC must move even while a freeze is requested.
  assign pc_en = ~mem_hold & (flush | ~(freeze_fd | freeze_dex));

  always_comb begin
    dec_d   = dec_q;
    ex_d    = ex_q;
    mem_d   = mem_q;
    stall_d = stall_q;

    if (mem_hold) begin
      // all three latches hold
    end else if (flush) begin
      dec_d = NOP_WORD;
      ex_d  = NOP_WORD;
      mem_d = ex_q;
    end else if (freeze_dex) begin
      mem_d = NOP_WORD;
    end else if (freeze_fd) begin
      ex_d  = NOP_WORD;
      mem_d = ex_q;
    end else begin
      dec_d = instr_fetch;
      ex_d  = dec_q;
      mem_d = ex_q;
    end

    if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_q   <= NOP_WORD;
      ex_q    <= NOP_WORD;
      mem_q   <= NOP_WORD;
      stall_q <= '0;
    end else begin
      dec_q   <= dec_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      stall_q <= stall_d;
    end
  end

  // Destination decode of the MEM word. JR is an R-type that writes nothing.
  always_comb begin
    rw_memory = 5'd0;
    case (mem_op)
      OP_SPECIAL: rw_memory = (mem_funct != FN_JR) ? mem_q[15:11] : 5'd0;
      OP_JAL:     rw_memory = 5'd31;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      OP_LW, OP_LL, OP_SC:
                  rw_memory = mem_q[20:16];
      default:    rw_memory = 5'd0;
    endcase
  end

  assign mem_regwrite = (rw_memory != 5'd0);

  assign instr_dec    = dec_q;
  assign instr_ex     = ex_q;
  assign instr_mem    = mem_q;
  assign rs_dec       = dec_q[25:21];
  assign rt_dec       = dec_q[20:16];
  assign rt_ex        = ex_q[20:16];
  assign rd_ex        = ex_q[15:11];
  assign rt_mem       = mem_q[20:16];
  assign rd_mem       = mem_q[15:11];
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Testbench for hazard_pipe_tracker: directed scenarios plus randomized
// traffic compared against a behavioural pipeline model.
module tb_hazard_pipe_tracker;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [31:0]      instr_fetch = '0;
  logic             freeze_fd = 1'b0, freeze_dex = 1'b0, flush = 1'b0, dhit = 1'b1;
  logic [31:0]      instr_dec, instr_ex, instr_mem;
  logic [4:0]       rs_dec, rt_dec, rt_ex, rd_ex, rt_mem, rd_mem, rw_memory;
  logic             mem_regwrite, pc_en;
  logic [CNT_W-1:0] stall_cycles;

  hazard_pipe_tracker #(.NOP_WORD(32'h0), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .instr_fetch(instr_fetch),
    .freeze_fd(freeze_fd), .freeze_dex(freeze_dex), .flush(flush), .dhit(dhit),
    .instr_dec(instr_dec), .instr_ex(instr_ex), .instr_mem(instr_mem),
    .rs_dec(rs_dec), .rt_dec(rt_dec), .rt_ex(rt_ex), .rd_ex(rd_ex),
    .rt_mem(rt_mem), .rd_mem(rd_mem), .rw_memory(rw_memory),
    .mem_regwrite(mem_regwrite), .pc_en(pc_en), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pipe[0]=DEC, pipe[1]=EX, pipe[2]=MEM
  logic [31:0] pipe [3];
  int          m_stall;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_mem_access(input logic [31:0] w);
    int op = int'(w[31:26]);
    return (op == 'h23) || (op == 'h2B) || (op == 'h30) || (op == 'h38);
  endfunction

  function automatic int ref_dest(input logic [31:0] w);
    int op = int'(w[31:26]);
    int d;
    if (op == 0) d = (w[5:0] == 6'h08) ? 0 : int'(w[15:11]);
    else if (op == 3) d = 31;
    else if ((op >= 8 && op <= 15) || op == 'h23 || op == 'h30 || op == 'h38) d = int'(w[20:16]);
    else d = 0;
    return d;
  endfunction

  // One clock: drive inputs at the falling edge, compare the current state and
  // combinational outputs, advance the model, and return just after the rising edge.
  task automatic step(input logic [31:0] f, input logic ffd, input logic fdx,
                      input logic fl, input logic dh, input logic rs);
    bit hold, pce;
    logic [31:0] nxt [3];
    @(negedge CLK);
    instr_fetch = f; freeze_fd = ffd; freeze_dex = fdx; flush = fl; dhit = dh; RST = rs;
    #1;
    hold = is_mem_access(pipe[2]) && !dh;
    pce  = !hold && (fl || !(ffd || fdx));
    check_val("instr_dec", instr_dec, pipe[0]);
    check_val("instr_ex", instr_ex, pipe[1]);
    check_val("instr_mem", instr_mem, pipe[2]);
    check_val("fields", {rs_dec, rt_dec, rt_ex, rd_ex, rt_mem, rd_mem},
              {pipe[0][25:21], pipe[0][20:16], pipe[1][20:16], pipe[1][15:11],
               pipe[2][20:16], pipe[2][15:11]});
    check_val("rw_memory", rw_memory, ref_dest(pipe[2]));
    check_val("mem_regwrite", mem_regwrite, ref_dest(pipe[2]) != 0);
    check_val("pc_en", pc_en, pce);
    check_val("stall_cycles", stall_cycles, m_stall);
    nxt = pipe;
    if (rs) begin
      nxt = '{32'h0, 32'h0, 32'h0};
      m_stall = 0;
    end else begin
      if (hold)      nxt = pipe;
      else if (fl)   nxt = '{32'h0, 32'h0, pipe[1]};
      else if (fdx)  nxt = '{pipe[0], pipe[1], 32'h0};
      else if (ffd)  nxt = '{pipe[0], 32'h0, pipe[1]};
      else           nxt = '{f, pipe[0], pipe[1]};
      if (!pce && m_stall < CNT_MAX) m_stall++;
    end
    @(posedge CLK);
    #1;
    pipe = nxt;
  endtask

  task automatic run(input logic [31:0] f);
    step(f, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h03, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h30, 6'h38, 6'h04};
    logic [31:0] w = $urandom;
    w[31:26] = ops[$urandom_range(0, 9)];
    if (w[31:26] == 6'h00 && $urandom_range(0, 3) == 0) w[5:0] = 6'h08;
    return w;
  endfunction

  localparam logic [31:0] ADDI1 = 32'h2001_0005;
  localparam logic [31:0] LW2   = 32'h8C02_0000;
  localparam logic [31:0] ADD3  = 32'h0043_1820;
  localparam logic [31:0] SW5   = 32'hAC05_0010;

  initial begin
    logic [31:0] dec_words [5] = '{32'h0000_1820, 32'h03E0_0008, 32'h0C00_0010,
                                   32'h2000_0005, 32'h1022_0004};
    int          dec_exp [5]   = '{3, 0, 31, 0, 0};

    pipe = '{32'h0, 32'h0, 32'h0};
    m_stall = 0;
    repeat (2) @(posedge CLK);

    // Reset state, with reset still asserted
    step(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("rst_pc_en", pc_en, 1'b1);

    // 1: free run of ADDI $1
    run(ADDI1); check_val("t1_dec", instr_dec, ADDI1);
    run(32'h0); check_val("t1_ex", instr_ex, ADDI1);
    run(32'h0); check_val("t1_mem", instr_mem, ADDI1);
    check_val("t1_rw", rw_memory, 5'd1);
    check_val("t1_regwr", mem_regwrite, 1'b1);
    check_val("t1_pc_en", pc_en, 1'b1);

    // 2: load-use freeze
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(LW2); run(ADD3);
    step(32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t2_dec", instr_dec, ADD3);
    check_val("t2_ex", instr_ex, 32'h0);
    check_val("t2_mem", instr_mem, LW2);
    check_val("t2_stall", stall_cycles, 1);

    // 3: flush beats freeze_dex
    run(ADDI1); run(ADD3);
    step(32'h1111_1111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("t3_dec", instr_dec, 32'h0);
    check_val("t3_ex", instr_ex, 32'h0);
    check_val("t3_mem", instr_mem, ADDI1);

    // 4: SW waiting on dcache for four edges
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(SW5); run(32'h0); run(32'h0);
    for (int i = 0; i < 4; i++) step(32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t4_mem_held", instr_mem, SW5);
    check_val("t4_stall", stall_cycles, 4);
    check_val("t4_rw", rw_memory, 5'd0);
    run(32'h0);
    check_val("t4_released", instr_mem, 32'h0);

    // 5: destination decode
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      run(i < 5 ? dec_words[i] : 32'h0);
      if (i >= 2) begin
        check_val($sformatf("t5_rw%0d", i - 2), rw_memory, dec_exp[i - 2]);
        check_val($sformatf("t5_we%0d", i - 2), mem_regwrite, dec_exp[i - 2] != 0);
      end
    end

    // 6: counter saturation, then reset mid-stall
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(LW2); run(32'h0); run(32'h0);
    for (int i = 0; i < CNT_MAX + 5; i++) step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t6_sat", stall_cycles, CNT_MAX);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("t6_rst_mem", instr_mem, 32'h0);
    check_val("t6_rst_cnt", stall_cycles, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(rand_instr(),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) >= 25,
           $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
